// File: rtl/alarm_pkg.sv
// Shared encodings and helpers for the daily alarm bank.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package alarm_pkg;

    // Which time field an inc/dec pulse acts on.
    typedef enum logic [1:0] {
        FIELD_SEC  = 2'd0,
        FIELD_MIN  = 2'd1,
        FIELD_HOUR = 2'd2,
        FIELD_NONE = 2'd3
    } field_e;

    // Per-channel alarm state.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RING   = 2'd1,
        ST_SNOOZE = 2'd2
    } alarm_state_e;

    localparam logic [4:0] MAX_HOUR    = 5'd23;
    localparam logic [5:0] MAX_MIN_SEC = 6'd59;

    // Binary 0..59 to two BCD digits.
    function automatic logic [7:0] bin2bcd(input logic [5:0] v);
        logic [3:0] tens;
        logic [3:0] units;
        tens  = 4'(v / 6'd10);
        units = 4'(v % 6'd10);
        return {tens, units};
    endfunction

    // One step up or down inside 0..max_v, wrapping at both ends, no carry out.
    function automatic logic [5:0] wrap_step(input logic [5:0] v,
                                             input logic [5:0] max_v,
                                             input logic       up);
        if (up) begin
            return (v >= max_v) ? 6'd0 : v + 6'd1;
        end
        return (v == 6'd0) ? max_v : v - 6'd1;
    endfunction

endpackage

// File: rtl/alarm_channel.sv
// One daily alarm: stored time-of-day, enable bit and IDLE/RINGING/SNOOZED FSM.
// Latency: edits and state changes are visible one clock after the strobe/tick.
// Backpressure: none; every strobe is consumed in the cycle it is presented.
module alarm_channel
    import alarm_pkg::*;
#(
    parameter int RING_SECS   = 60,
    parameter int SNOOZE_SECS = 300
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       tick_1hz,
    input  logic [4:0] cur_hour,
    input  logic [5:0] cur_minute,
    input  logic [5:0] cur_second,
    input  logic [1:0] edit_field,
    input  logic       inc,
    input  logic       dec,
    input  logic       toggle_en,
    input  logic       snooze,
    input  logic       stop,
    output logic [4:0] alm_hour,
    output logic [5:0] alm_minute,
    output logic [5:0] alm_second,
    output logic       enabled,
    output logic       ringing
);

    // Counter must hold the larger of the two reload values.
    localparam int MAX_SECS = (RING_SECS > SNOOZE_SECS) ? RING_SECS : SNOOZE_SECS;
    localparam int CNT_W    = $clog2(MAX_SECS + 1);
    localparam logic [CNT_W-1:0] RING_LOAD   = CNT_W'(RING_SECS - 1);
    localparam logic [CNT_W-1:0] SNOOZE_LOAD = CNT_W'(SNOOZE_SECS - 1);

    alarm_state_e     state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             time_match;
    logic             disable_now;

    assign time_match  = (cur_hour == alm_hour) && (cur_minute == alm_minute) &&
                         (cur_second == alm_second);
    // Only a 1->0 transition of the enable bit silences the channel.
    assign disable_now = toggle_en && enabled;
    assign ringing     = (state_q == ST_RING);

    // Alarm time and enable registers; inc together with dec cancels out.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alm_hour   <= 5'd0;
            alm_minute <= 6'd0;
            alm_second <= 6'd0;
            enabled    <= 1'b0;
        end else begin
            if (inc ^ dec) begin
                case (edit_field)
                    FIELD_SEC:  alm_second <= wrap_step(alm_second, MAX_MIN_SEC, inc);
                    FIELD_MIN:  alm_minute <= wrap_step(alm_minute, MAX_MIN_SEC, inc);
                    FIELD_HOUR: alm_hour   <= 5'(wrap_step({1'b0, alm_hour},
                                                           {1'b0, MAX_HOUR}, inc));
                    default:    ;
                endcase
            end
            if (toggle_en) begin
                enabled <= ~enabled;
            end
        end
    end

    // FSM state and seconds counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next state: stop beats disable beats snooze beats 1 Hz events.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (disable_now) begin
            state_d = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (tick_1hz && enabled && time_match) begin
                        state_d = ST_RING;
                        cnt_d   = RING_LOAD;
                    end
                end
                ST_RING: begin
                    if (snooze) begin
                        state_d = ST_SNOOZE;
                        cnt_d   = SNOOZE_LOAD;
                    end else if (tick_1hz) begin
                        if (cnt_q == '0) begin
                            state_d = ST_IDLE;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_SNOOZE: begin
                    if (tick_1hz) begin
                        if (cnt_q == '0) begin
                            state_d = ST_RING;
                            cnt_d   = RING_LOAD;
                        end else begin
                            cnt_d = cnt_q - CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: rtl/alarm_bank.sv
// Bank of daily alarms: channel select/edit, BCD display of the selected alarm, buzzer drive.
// Latency: edits and ring flags update one clock after the strobe/tick; display is combinational.
// Backpressure: none; all pulses are single-cycle and always accepted.
module alarm_bank
    import alarm_pkg::*;
#(
    parameter  int NUM_ALARMS  = 4,
    parameter  int RING_SECS   = 60,
    parameter  int SNOOZE_SECS = 300,
    localparam int IDX_W       = $clog2(NUM_ALARMS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick_1hz,
    input  logic [4:0]            cur_hour,
    input  logic [5:0]            cur_minute,
    input  logic [5:0]            cur_second,
    input  logic                  edit_en,
    input  logic [1:0]            edit_field,
    input  logic                  sel_next,
    input  logic                  inc,
    input  logic                  dec,
    input  logic                  toggle_en,
    input  logic                  snooze,
    input  logic                  stop,
    output logic [IDX_W-1:0]      sel_idx,
    output logic [7:0]            sel_hour_bcd,
    output logic [7:0]            sel_minute_bcd,
    output logic [7:0]            sel_second_bcd,
    output logic                  sel_enabled,
    output logic [NUM_ALARMS-1:0] ring_mask,
    output logic                  ring,
    output logic [IDX_W-1:0]      ring_idx
);

    logic [NUM_ALARMS-1:0] inc_vec;
    logic [NUM_ALARMS-1:0] dec_vec;
    logic [NUM_ALARMS-1:0] tog_vec;
    logic [NUM_ALARMS-1:0] en_vec;
    logic [4:0]            hour_arr   [NUM_ALARMS];
    logic [5:0]            minute_arr [NUM_ALARMS];
    logic [5:0]            second_arr [NUM_ALARMS];

    // Selected-channel pointer, wraps from the last channel back to 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel_idx <= '0;
        end else if (edit_en && sel_next) begin
            if (sel_idx == IDX_W'(NUM_ALARMS - 1)) begin
                sel_idx <= '0;
            end else begin
                sel_idx <= sel_idx + IDX_W'(1);
            end
        end
    end

    // Route edit strobes to the selected channel only, and only in edit mode.
    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        tog_vec = '0;
        for (int i = 0; i < NUM_ALARMS; i++) begin
            if (edit_en && (sel_idx == IDX_W'(i))) begin
                inc_vec[i] = inc;
                dec_vec[i] = dec;
                tog_vec[i] = toggle_en;
            end
        end
    end

    for (genvar g = 0; g < NUM_ALARMS; g++) begin : g_ch
        alarm_channel #(
            .RING_SECS   (RING_SECS),
            .SNOOZE_SECS (SNOOZE_SECS)
        ) u_ch (
            .clk        (clk),
            .rst_n      (rst_n),
            .tick_1hz   (tick_1hz),
            .cur_hour   (cur_hour),
            .cur_minute (cur_minute),
            .cur_second (cur_second),
            .edit_field (edit_field),
            .inc        (inc_vec[g]),
            .dec        (dec_vec[g]),
            .toggle_en  (tog_vec[g]),
            .snooze     (snooze),
            .stop       (stop),
            .alm_hour   (hour_arr[g]),
            .alm_minute (minute_arr[g]),
            .alm_second (second_arr[g]),
            .enabled    (en_vec[g]),
            .ringing    (ring_mask[g])
        );
    end

    // Display mux: selected alarm time converted to BCD.
    always_comb begin
        sel_hour_bcd   = bin2bcd({1'b0, hour_arr[sel_idx]});
        sel_minute_bcd = bin2bcd(minute_arr[sel_idx]);
        sel_second_bcd = bin2bcd(second_arr[sel_idx]);
        sel_enabled    = en_vec[sel_idx];
    end

    assign ring = |ring_mask;

    // Lowest-index ringing channel wins; scanning downward leaves the lowest hit.
    always_comb begin
        ring_idx = '0;
        for (int i = NUM_ALARMS - 1; i >= 0; i--) begin
            if (ring_mask[i]) begin
                ring_idx = IDX_W'(i);
            end
        end
    end

endmodule

// File: tb/tb_alarm_bank.sv
// Bench for alarm_bank: edit vector table, then ring/snooze/stop/disable/reset sequences.
// Latency: expectations are queued at drive time and checked one clock later.
// Backpressure: n/a.
module tb_alarm_bank;
    localparam int N  = 4;
    localparam int RS = 60;
    localparam int SS = 300;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       tick_1hz;
    logic [4:0] cur_hour;
    logic [5:0] cur_minute, cur_second;
    logic       edit_en;
    logic [1:0] edit_field;
    logic       sel_next, inc, dec, toggle_en, snooze, stop;
    logic [1:0] sel_idx;
    logic [7:0] sel_hour_bcd, sel_minute_bcd, sel_second_bcd;
    logic       sel_enabled;
    logic [3:0] ring_mask;
    logic       ring;
    logic [1:0] ring_idx;

    always #5 clk = ~clk;

    alarm_bank #(.NUM_ALARMS(N), .RING_SECS(RS), .SNOOZE_SECS(SS)) dut (
        .clk(clk), .rst_n(rst_n), .tick_1hz(tick_1hz), .cur_hour(cur_hour),
        .cur_minute(cur_minute), .cur_second(cur_second), .edit_en(edit_en),
        .edit_field(edit_field), .sel_next(sel_next), .inc(inc), .dec(dec),
        .toggle_en(toggle_en), .snooze(snooze), .stop(stop), .sel_idx(sel_idx),
        .sel_hour_bcd(sel_hour_bcd), .sel_minute_bcd(sel_minute_bcd),
        .sel_second_bcd(sel_second_bcd), .sel_enabled(sel_enabled),
        .ring_mask(ring_mask), .ring(ring), .ring_idx(ring_idx)
    );

    typedef struct {
        string      name;
        bit         cs;      // compare selection/display outputs
        bit         cr;      // compare ring outputs
        logic [1:0] sel;
        logic [7:0] h, m, s;
        logic       en;
        logic [3:0] mask;
        logic       rg;
        logic [1:0] ridx;
    } exp_t;

    typedef struct {
        logic       tick;
        logic [4:0] ch;
        logic [5:0] cm, csec;
        logic       ee;
        logic [1:0] fld;
        logic       sn, inc, dec, tog, snz, stp;
        exp_t       e;
    } vec_t;

    exp_t sb[$];
    int   n_vec   = 0;
    int   n_bad   = 0;
    int   cur_sel = 0;

    function automatic exp_t no_exp();
        exp_t e;
        e.name = ""; e.cs = 1'b0; e.cr = 1'b0; e.sel = '0;
        e.h = '0; e.m = '0; e.s = '0; e.en = 1'b0;
        e.mask = '0; e.rg = 1'b0; e.ridx = '0;
        return e;
    endfunction

    function automatic exp_t sexp(string nm, logic [1:0] sel, logic [7:0] h, logic [7:0] m,
                                  logic [7:0] s, logic en);
        exp_t e = no_exp();
        e.name = nm; e.cs = 1'b1; e.sel = sel; e.h = h; e.m = m; e.s = s; e.en = en;
        return e;
    endfunction

    function automatic exp_t rexp(string nm, logic [3:0] mask, logic [1:0] ridx);
        exp_t e = no_exp();
        e.name = nm; e.cr = 1'b1; e.mask = mask; e.rg = (mask != 4'b0000); e.ridx = ridx;
        return e;
    endfunction

    function automatic vec_t idle_v();
        vec_t v;
        v.tick = 1'b0; v.ch = 5'd12; v.cm = 6'd0; v.csec = 6'd0; v.ee = 1'b0; v.fld = 2'd3;
        v.sn = 1'b0; v.inc = 1'b0; v.dec = 1'b0; v.tog = 1'b0; v.snz = 1'b0; v.stp = 1'b0;
        v.e = no_exp();
        return v;
    endfunction

    function automatic vec_t tk(int h, int m, int s);
        vec_t v = idle_v();
        v.tick = 1'b1; v.ch = 5'(h); v.cm = 6'(m); v.csec = 6'(s);
        return v;
    endfunction

    function automatic vec_t ed(logic ee, logic [1:0] f, logic sn, logic i, logic d, logic t);
        vec_t v = idle_v();
        v.ee = ee; v.fld = f; v.sn = sn; v.inc = i; v.dec = d; v.tog = t;
        return v;
    endfunction

    // Edit vector that also checks the full output set (nothing ringing).
    function automatic vec_t ev(string nm, logic ee, logic [1:0] f, logic sn, logic i, logic d,
                                logic t, logic [1:0] xs, logic [7:0] xh, logic [7:0] xm,
                                logic [7:0] xsec, logic xen);
        vec_t v = ed(ee, f, sn, i, d, t);
        v.e = sexp(nm, xs, xh, xm, xsec, xen);
        v.e.cr = 1'b1;
        return v;
    endfunction

    task automatic check_exp(input exp_t e);
        bit bad = 1'b0;
        if (e.cs && ({sel_idx, sel_hour_bcd, sel_minute_bcd, sel_second_bcd, sel_enabled} !==
                     {e.sel, e.h, e.m, e.s, e.en})) bad = 1'b1;
        if (e.cr && ({ring_mask, ring, ring_idx} !== {e.mask, e.rg, e.ridx})) bad = 1'b1;
        n_vec++;
        if (bad) begin
            n_bad++;
            $display("FAIL %s: got sel=%0d t=%h:%h:%h en=%b mask=%b ring=%b ridx=%0d, want sel=%0d t=%h:%h:%h en=%b mask=%b ring=%b ridx=%0d",
                     e.name, sel_idx, sel_hour_bcd, sel_minute_bcd, sel_second_bcd, sel_enabled,
                     ring_mask, ring, ring_idx, e.sel, e.h, e.m, e.s, e.en, e.mask, e.rg, e.ridx);
        end
    endtask

    // Drive one cycle of stimulus, queue its expectation, compare after the edge.
    task automatic step(input vec_t v);
        @(negedge clk);
        tick_1hz = v.tick; cur_hour = v.ch; cur_minute = v.cm; cur_second = v.csec;
        edit_en = v.ee; edit_field = v.fld; sel_next = v.sn; inc = v.inc; dec = v.dec;
        toggle_en = v.tog; snooze = v.snz; stop = v.stp;
        if (v.e.cs || v.e.cr) sb.push_back(v.e);
        @(posedge clk);
        #1;
        tick_1hz = 1'b0; sel_next = 1'b0; inc = 1'b0; dec = 1'b0;
        toggle_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        if (sb.size() != 0) check_exp(sb.pop_front());
    endtask

    task automatic goto_ch(input int ch);
        while (cur_sel != ch) begin
            step(ed(1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b0));
            cur_sel = (cur_sel + 1) % N;
        end
    endtask

    // Program a channel that currently holds 00:00:00 and is disabled.
    task automatic set_time(input int ch, input int h, input int m, input int s, input bit en);
        goto_ch(ch);
        repeat (h) step(ed(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (m) step(ed(1'b1, 2'd1, 1'b0, 1'b1, 1'b0, 1'b0));
        repeat (s) step(ed(1'b1, 2'd0, 1'b0, 1'b1, 1'b0, 1'b0));
        if (en) step(ed(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation still running at %0t, required to finish earlier", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        vec_t v;
        exp_t e;
        vec_t tbl[19];

        rst_n = 1'b0; tick_1hz = 1'b0; cur_hour = '0; cur_minute = '0; cur_second = '0;
        edit_en = 1'b0; edit_field = 2'd3; sel_next = 1'b0; inc = 1'b0; dec = 1'b0;
        toggle_en = 1'b0; snooze = 1'b0; stop = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        //        name            ee fld sn inc dec tog  sel  hh     mm     ss     en
        tbl[0]  = ev("rst_state",   0, 3, 0, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        tbl[1]  = ev("sel_1",       1, 3, 1, 0, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[2]  = ev("sel_2",       1, 3, 1, 0, 0, 0, 2'd2, 8'h00, 8'h00, 8'h00, 0);
        tbl[3]  = ev("sel_3",       1, 3, 1, 0, 0, 0, 2'd3, 8'h00, 8'h00, 8'h00, 0);
        tbl[4]  = ev("sel_wrap",    1, 3, 1, 0, 0, 0, 2'd0, 8'h00, 8'h00, 8'h00, 0);
        tbl[5]  = ev("sel_5th",     1, 3, 1, 0, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[6]  = ev("hr_dec_wrap", 1, 2, 0, 0, 1, 0, 2'd1, 8'h23, 8'h00, 8'h00, 0);
        tbl[7]  = ev("hr_inc_wrap", 1, 2, 0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[8]  = ev("inc_dec_nop", 1, 2, 0, 1, 1, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[9]  = ev("min_dec",     1, 1, 0, 0, 1, 0, 2'd1, 8'h00, 8'h59, 8'h00, 0);
        tbl[10] = ev("min_inc",     1, 1, 0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[11] = ev("sec_dec",     1, 0, 0, 0, 1, 0, 2'd1, 8'h00, 8'h00, 8'h59, 0);
        tbl[12] = ev("field_none",  1, 3, 0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 8'h59, 0);
        tbl[13] = ev("sec_inc",     1, 0, 0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[14] = ev("noedit_inc",  0, 0, 0, 1, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[15] = ev("noedit_sel",  0, 3, 1, 0, 0, 0, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[16] = ev("noedit_tog",  0, 3, 0, 0, 0, 1, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        tbl[17] = ev("tog_on",      1, 3, 0, 0, 0, 1, 2'd1, 8'h00, 8'h00, 8'h00, 1);
        tbl[18] = ev("tog_off",     1, 3, 0, 0, 0, 1, 2'd1, 8'h00, 8'h00, 8'h00, 0);
        for (int i = 0; i < 19; i++) step(tbl[i]);
        cur_sel = 1;

        // Ch2 rings at 07:30:00 and auto-stops after RS ticks.
        set_time(2, 7, 30, 0, 1'b1);
        v = idle_v(); v.e = sexp("ch2_disp", 2'd2, 8'h07, 8'h30, 8'h00, 1'b1); step(v);
        v = tk(7, 29, 59); v.e = rexp("ch2_no_early", 4'b0000, 2'd0); step(v);
        v = tk(7, 30, 0);  v.e = rexp("ch2_ring", 4'b0100, 2'd2); step(v);
        for (int i = 1; i <= RS; i++) begin
            v = tk(12, 0, 0);
            if (i == RS - 1) v.e = rexp("ch2_last_sec", 4'b0100, 2'd2);
            else if (i == RS) v.e = rexp("ch2_autostop", 4'b0000, 2'd0);
            step(v);
        end
        v = idle_v(); v.e = sexp("ch2_still_en", 2'd2, 8'h07, 8'h30, 8'h00, 1'b1); step(v);

        // Ch0 rings, snoozes, re-rings after SS ticks, then stops.
        set_time(0, 8, 0, 0, 1'b1);
        v = tk(8, 0, 0); v.e = rexp("ch0_ring", 4'b0001, 2'd0); step(v);
        v = idle_v(); v.snz = 1'b1; v.e = rexp("ch0_snoozed", 4'b0000, 2'd0); step(v);
        for (int i = 1; i <= SS; i++) begin
            v = tk(12, 0, 0);
            if (i == SS - 1) v.e = rexp("ch0_snz_last", 4'b0000, 2'd0);
            else if (i == SS) v.e = rexp("ch0_rering", 4'b0001, 2'd0);
            step(v);
        end
        v = idle_v(); v.stp = 1'b1; v.e = rexp("ch0_stop", 4'b0000, 2'd0); step(v);

        // Ch1 and ch3 ring together; stop+snooze in one cycle leaves both idle.
        set_time(1, 9, 15, 30, 1'b1);
        set_time(3, 9, 15, 30, 1'b1);
        v = tk(9, 15, 30); v.e = rexp("ch13_ring", 4'b1010, 2'd1); step(v);
        v = idle_v(); v.stp = 1'b1; v.snz = 1'b1; v.e = rexp("stop_beats_snz", 4'b0000, 2'd0);
        step(v);
        for (int i = 1; i <= SS + 5; i++) begin
            v = tk(12, 0, 0);
            if (i == SS + 5) v.e = rexp("no_rering", 4'b0000, 2'd0);
            step(v);
        end

        // Disabled channel ignores its match; disabling a ringing channel silences it.
        goto_ch(1);
        v = ed(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        v.e = sexp("ch1_off", 2'd1, 8'h09, 8'h15, 8'h30, 1'b0); step(v);
        v = tk(9, 15, 30); v.e = rexp("ch3_only", 4'b1000, 2'd3); step(v);
        goto_ch(3);
        v = ed(1'b1, 2'd2, 1'b0, 1'b1, 1'b0, 1'b0);
        v.e = sexp("edit_ringing", 2'd3, 8'h10, 8'h15, 8'h30, 1'b1);
        v.e.cr = 1'b1; v.e.mask = 4'b1000; v.e.rg = 1'b1; v.e.ridx = 2'd3; step(v);
        step(ed(1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0));
        v = ed(1'b1, 2'd3, 1'b0, 1'b0, 1'b0, 1'b1);
        v.e = sexp("disable_ring", 2'd3, 8'h09, 8'h15, 8'h30, 1'b0);
        v.e.cr = 1'b1; step(v);
        v = tk(9, 15, 30); v.e = rexp("dis_match", 4'b0000, 2'd0); step(v);

        // Asynchronous reset in the middle of a ring.
        v = tk(8, 0, 0); v.e = rexp("ch0_ring2", 4'b0001, 2'd0); step(v);
        #2;
        rst_n = 1'b0;
        #1;
        e = sexp("async_rst", 2'd0, 8'h00, 8'h00, 8'h00, 1'b0);
        e.cr = 1'b1;
        sb.push_back(e);
        check_exp(sb.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        cur_sel = 0;
        v = tk(8, 0, 0);  v.e = rexp("post_rst_ch0", 4'b0000, 2'd0); step(v);
        v = tk(7, 30, 0); v.e = rexp("post_rst_ch2", 4'b0000, 2'd0); step(v);
        goto_ch(2);
        v = idle_v(); v.e = sexp("post_rst_ch2_disp", 2'd2, 8'h00, 8'h00, 8'h00, 1'b0); step(v);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
